// File: rtl/add_bits_sched_if.sv
// Job request / result handshake bundle between requesters and the add_bits scheduler.
interface add_bits_sched_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_r;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_r;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_id;
  logic             rsp_err;

  modport master (
    output req_valid, req0_x, req0_r, req1_x, req1_r, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req0_x, req0_r, req1_x, req1_r, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id, rsp_err
  );
endinterface

// File: rtl/add_bits_sched.sv
// Two-requester round-robin job scheduler for a single add_bits engine,
// with a watchdog that aborts jobs whose engine never settles.
module add_bits_sched #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  add_bits_sched_if.slave  bus,
  output logic [WIDTH-1:0] eng_x,
  output logic [WIDTH-1:0] eng_r,
  output logic             eng_reset,
  input  logic [WIDTH-1:0] eng_y,
  input  logic             eng_dirty,
  output logic             busy
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [1:0]      grant_c;
  logic            ptr_q;
  logic [WD_W-1:0] wd_q;

  // Round-robin grant; ptr_q high means requester 1 wins a tie.
  always_comb begin
    grant_c = 2'b00;
    if (state_q == IDLE) begin
      case (bus.req_valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = ptr_q ? 2'b10 : 2'b01;
        default: grant_c = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant_c != 2'b00) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (!eng_dirty || (wd_q == WD_LAST)) state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 1'b0;
    eng_reset     = 1'b0;
    busy          = 1'b0;
    bus.req_ready = grant_c;
    bus.rsp_valid = (state_q == RESP);
    eng_reset     = (state_q == LOAD);
    busy          = (state_q != IDLE);
  end

  // Job capture, watchdog and result registers; a settled engine beats the watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= 1'b0;
      wd_q        <= '0;
      eng_x       <= '0;
      eng_r       <= '0;
      bus.rsp_y   <= '0;
      bus.rsp_id  <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_c != 2'b00) begin
            eng_x      <= grant_c[1] ? bus.req1_x : bus.req0_x;
            eng_r      <= grant_c[1] ? bus.req1_r : bus.req0_r;
            bus.rsp_id <= grant_c[1];
            ptr_q      <= grant_c[0];
          end
        end
        LOAD: wd_q <= '0;
        RUN: begin
          wd_q <= wd_q + WD_W'(1);
          if (!eng_dirty) begin
            bus.rsp_y   <= eng_y;
            bus.rsp_err <= 1'b0;
          end else if (wd_q == WD_LAST) begin
            bus.rsp_y   <= '0;
            bus.rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_bits_sched.sv
// Bench for add_bits_sched: two instances (long and short watchdog) share one stimulus stream
// and are checked every cycle against a job-timeline model, plus directed literal scenarios.
module tb_add_bits_sched;
  localparam int unsigned W  = 32;
  localparam int unsigned T0 = 1024;
  localparam int unsigned T1 = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]   d_valid;
  logic         d_rready;
  logic [W-1:0] d0x, d0r, d1x, d1r;
  logic [W-1:0] p0x, p0r, p1x, p1r;
  int unsigned  d_lat;

  add_bits_sched_if #(.WIDTH(W)) bus0 ();
  add_bits_sched_if #(.WIDTH(W)) bus1 ();

  assign bus0.req_valid = d_valid;  assign bus1.req_valid = d_valid;
  assign bus0.rsp_ready = d_rready; assign bus1.rsp_ready = d_rready;
  assign bus0.req0_x = d0x; assign bus0.req0_r = d0r; assign bus0.req1_x = d1x; assign bus0.req1_r = d1r;
  assign bus1.req0_x = d0x; assign bus1.req0_r = d0r; assign bus1.req1_x = d1x; assign bus1.req1_r = d1r;

  logic [W-1:0] eng_x [2];
  logic [W-1:0] eng_r [2];
  logic [W-1:0] eng_y [2];
  logic         eng_reset [2];
  logic         eng_dirty [2];
  logic         o_busy [2];

  add_bits_sched #(.WIDTH(W), .TIMEOUT(T0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .eng_x(eng_x[0]), .eng_r(eng_r[0]), .eng_reset(eng_reset[0]),
    .eng_y(eng_y[0]), .eng_dirty(eng_dirty[0]), .busy(o_busy[0])
  );

  add_bits_sched #(.WIDTH(W), .TIMEOUT(T1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .eng_x(eng_x[1]), .eng_r(eng_r[1]), .eng_reset(eng_reset[1]),
    .eng_y(eng_y[1]), .eng_dirty(eng_dirty[1]), .busy(o_busy[1])
  );

  logic [1:0]   o_ready [2];
  logic         o_rv [2];
  logic         o_id [2];
  logic         o_err [2];
  logic [W-1:0] o_y [2];
  assign o_ready[0] = bus0.req_ready; assign o_ready[1] = bus1.req_ready;
  assign o_rv[0] = bus0.rsp_valid;    assign o_rv[1] = bus1.rsp_valid;
  assign o_id[0] = bus0.rsp_id;       assign o_id[1] = bus1.rsp_id;
  assign o_err[0] = bus0.rsp_err;     assign o_err[1] = bus1.rsp_err;
  assign o_y[0] = bus0.rsp_y;         assign o_y[1] = bus1.rsp_y;

  // Engine model: dirty for job_lat cycles after the start pulse, then y = x + r.
  int unsigned job_lat [2];
  for (genvar g = 0; g < 2; g++) begin : g_eng
    int unsigned  cnt = 0;
    logic [W-1:0] lx = '0;
    logic [W-1:0] lr = '0;
    always @(posedge clk) begin
      if (eng_reset[g]) begin
        cnt <= job_lat[g];
        lx  <= eng_x[g];
        lr  <= eng_r[g];
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
    assign eng_dirty[g] = (cnt != 0);
    assign eng_y[g]     = (cnt != 0) ? ~(lx + lr) : (lx + lr);
  end

  int checks = 0;
  int errors = 0;

  // Job-timeline model: m_k counts cycles since the accepting edge.
  bit           m_act [2] = '{1'b0, 1'b0};
  bit           m_ptr [2] = '{1'b0, 1'b0};
  int           m_k [2];
  int           m_n [2];
  bit           m_err [2];
  bit           m_id [2];
  logic [W-1:0] m_y [2];
  logic [W-1:0] m_ex [2] = '{'0, '0};
  logic [W-1:0] m_er [2] = '{'0, '0};

  logic [1:0]   s_ready [2];
  logic         s_rv [2], s_id [2], s_err [2], s_er [2], s_busy [2];
  logic [W-1:0] s_y [2], s_ex [2], s_erop [2];

  int           first [2];
  int           erc [2];
  logic [W-1:0] fy [2];
  logic         ferr [2];
  logic         fid [2];

  function automatic int tmo(input int i);
    return (i == 0) ? int'(T0) : int'(T1);
  endfunction

  function automatic logic [1:0] arb(input logic [1:0] v, input bit p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", nm, i, act, exp);
    end
  endtask

  task automatic compare();
    logic [1:0] xr;
    bit         xrv;
    for (int i = 0; i < 2; i++) begin
      xr  = m_act[i] ? 2'b00 : arb(d_valid, m_ptr[i]);
      xrv = m_act[i] && (m_k[i] >= m_n[i] + 2);
      chk("req_ready", i, 64'(o_ready[i]), 64'(xr));
      chk("busy", i, 64'(o_busy[i]), 64'(m_act[i]));
      chk("eng_reset", i, 64'(eng_reset[i]), 64'(m_act[i] && m_k[i] == 1));
      chk("rsp_valid", i, 64'(o_rv[i]), 64'(xrv));
      chk("eng_x", i, 64'(eng_x[i]), 64'(m_ex[i]));
      chk("eng_r", i, 64'(eng_r[i]), 64'(m_er[i]));
      if (xrv) begin
        chk("rsp_y", i, 64'(o_y[i]), 64'(m_y[i]));
        chk("rsp_id", i, 64'(o_id[i]), 64'(m_id[i]));
        chk("rsp_err", i, 64'(o_err[i]), 64'(m_err[i]));
      end
      s_ready[i] = o_ready[i]; s_rv[i] = o_rv[i]; s_id[i] = o_id[i]; s_err[i] = o_err[i];
      s_er[i] = eng_reset[i]; s_busy[i] = o_busy[i]; s_y[i] = o_y[i];
      s_ex[i] = eng_x[i]; s_erop[i] = eng_r[i];
    end
  endtask

  task automatic model_edge();
    logic [1:0] g;
    int         lat1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_act[i] = 1'b0; m_ptr[i] = 1'b0; m_ex[i] = '0; m_er[i] = '0;
      end else if (!m_act[i]) begin
        g = arb(d_valid, m_ptr[i]);
        if (g != 2'b00) begin
          m_act[i]   = 1'b1;
          m_k[i]     = 1;
          m_id[i]    = g[1];
          m_ex[i]    = g[1] ? d1x : d0x;
          m_er[i]    = g[1] ? d1r : d0r;
          m_ptr[i]   = g[0];
          job_lat[i] = d_lat;
          lat1       = int'(d_lat) + 1;
          m_n[i]     = (lat1 < tmo(i)) ? lat1 : tmo(i);
          m_err[i]   = (lat1 > tmo(i));
          m_y[i]     = m_err[i] ? '0 : (m_ex[i] + m_er[i]);
        end
      end else if ((m_k[i] >= m_n[i] + 2) && d_rready) begin
        m_act[i] = 1'b0;
      end else begin
        m_k[i]++;
      end
    end
  endtask

  task automatic step(input bit rst, input logic [1:0] v, input bit rr, input int unsigned lat, input bit rnd);
    @(negedge clk);
    reset = rst; d_valid = v; d_rready = rr; d_lat = lat;
    if (rnd) begin
      d0x = $urandom; d0r = $urandom; d1x = $urandom; d1r = $urandom;
    end else begin
      d0x = p0x; d0r = p0r; d1x = p1x; d1r = p1r;
    end
    #1;
    compare();
    @(posedge clk);
    model_edge();
  endtask

  task automatic watch(input int nsteps, input int unsigned lat, input bit rnd);
    for (int i = 0; i < 2; i++) begin
      first[i] = -1; erc[i] = 0;
    end
    for (int k = 1; k <= nsteps; k++) begin
      step(1'b0, 2'b00, 1'b1, lat, rnd);
      for (int i = 0; i < 2; i++) begin
        if (s_er[i]) erc[i]++;
        if (s_rv[i] && first[i] < 0) begin
          first[i] = k; fy[i] = s_y[i]; ferr[i] = s_err[i]; fid[i] = s_id[i];
        end
      end
    end
  endtask

  initial begin
    int gq [2][$];
    int iq [2][$];
    int rvc [2];
    reset = 1'b1; d_valid = 2'b00; d_rready = 1'b1; d_lat = 0;
    d0x = '0; d0r = '0; d1x = '0; d1r = '0;
    p0x = '0; p0r = '0; p1x = '0; p1r = '0;
    job_lat = '{0, 0};

    // Reset state
    repeat (3) step(1'b1, 2'b00, 1'b1, 0, 1'b1);
    step(1'b0, 2'b00, 1'b1, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rsp_valid", i, 64'(s_rv[i]), 64'd0);
      chk("rst_rsp_y", i, 64'(s_y[i]), 64'd0);
      chk("rst_rsp_err", i, 64'(s_err[i]), 64'd0);
      chk("rst_busy", i, 64'(s_busy[i]), 64'd0);
      chk("rst_eng_x", i, 64'(s_ex[i]), 64'd0);
    end

    // Single job on requester 0, engine settles after 40 cycles
    p0x = 32'h0000_0003; p0r = 32'h0000_0001;
    step(1'b0, 2'b01, 1'b1, 40, 1'b0);
    watch(60, 40, 1'b0);
    chk("single_latency", 0, 64'(first[0]), 64'd43);
    chk("single_y", 0, 64'(fy[0]), 64'h4);
    chk("single_err", 0, 64'(ferr[0]), 64'd0);
    chk("single_id", 0, 64'(fid[0]), 64'd0);
    chk("single_eng_reset_w", 0, 64'(erc[0]), 64'd1);
    chk("timeout_latency", 1, 64'(first[1]), 64'd18);
    chk("timeout_y", 1, 64'(fy[1]), 64'd0);
    chk("timeout_err", 1, 64'(ferr[1]), 64'd1);
    chk("timeout_eng_reset_w", 1, 64'(erc[1]), 64'd1);

    // Contention: both requesters valid throughout
    repeat (2) step(1'b1, 2'b00, 1'b1, 0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 2'b11, 1'b1, 3, 1'b1);
      for (int i = 0; i < 2; i++) begin
        if (s_ready[i] != 2'b00) gq[i].push_back(int'(s_ready[i][1]));
        if (s_rv[i]) iq[i].push_back(int'(s_id[i]));
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk("grant_count_ok", i, 64'(gq[i].size() >= 4), 64'd1);
      chk("rsp_count_ok", i, 64'(iq[i].size() >= 4), 64'd1);
      for (int j = 0; j < 4 && j < gq[i].size() && j < iq[i].size(); j++) begin
        chk("grant_seq", i, 64'(gq[i][j]), 64'(j % 2));
        chk("rsp_id_seq", i, 64'(iq[i][j]), 64'(j % 2));
      end
    end

    // Backpressure: rsp_ready low for 10 RESP cycles
    repeat (2) step(1'b1, 2'b00, 1'b1, 0, 1'b1);
    step(1'b0, 2'b10, 1'b0, 2, 1'b1);
    rvc = '{0, 0};
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 2'b11, 1'b0, 2, 1'b1);
      for (int i = 0; i < 2; i++) if (s_rv[i]) rvc[i]++;
    end
    step(1'b0, 2'b11, 1'b1, 2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("bp_hold_cycles", i, 64'(rvc[i]), 64'd10);
      chk("bp_id", i, 64'(s_id[i]), 64'd1);
      chk("bp_final_valid", i, 64'(s_rv[i]), 64'd1);
    end
    step(1'b0, 2'b00, 1'b1, 2, 1'b1);
    for (int i = 0; i < 2; i++) chk("bp_done_busy", i, 64'(s_busy[i]), 64'd0);

    // Reset during the fifth RUN cycle, then a requester-1-only job
    repeat (2) step(1'b1, 2'b00, 1'b1, 0, 1'b1);
    step(1'b0, 2'b10, 1'b1, 20, 1'b1);
    repeat (5) step(1'b0, 2'b00, 1'b1, 20, 1'b1);
    step(1'b1, 2'b00, 1'b1, 20, 1'b1);
    step(1'b0, 2'b00, 1'b1, 1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("midrst_busy", i, 64'(s_busy[i]), 64'd0);
      chk("midrst_eng_reset", i, 64'(s_er[i]), 64'd0);
      chk("midrst_rsp_valid", i, 64'(s_rv[i]), 64'd0);
      chk("midrst_rsp_id", i, 64'(s_id[i]), 64'd0);
      chk("midrst_eng_r", i, 64'(s_erop[i]), 64'd0);
    end
    step(1'b0, 2'b10, 1'b1, 1, 1'b1);
    for (int i = 0; i < 2; i++) chk("midrst_grant", i, 64'(s_ready[i]), 64'h2);
    watch(10, 1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk("midrst_job_latency", i, 64'(first[i]), 64'd4);
      chk("midrst_job_id", i, 64'(fid[i]), 64'd1);
    end

    // Engine settles exactly on the watchdog's last cycle, then one cycle later
    p1x = 32'h1234_5678; p1r = 32'h1111_1111;
    repeat (2) step(1'b1, 2'b00, 1'b1, 0, 1'b0);
    step(1'b0, 2'b10, 1'b1, 15, 1'b0);
    watch(25, 15, 1'b0);
    chk("edge_latency", 1, 64'(first[1]), 64'd18);
    chk("edge_err", 1, 64'(ferr[1]), 64'd0);
    chk("edge_y", 1, 64'(fy[1]), 64'h2345_6789);
    repeat (2) step(1'b1, 2'b00, 1'b1, 0, 1'b0);
    step(1'b0, 2'b10, 1'b1, 16, 1'b0);
    watch(25, 16, 1'b0);
    chk("late_latency", 0, 64'(first[0]), 64'd19);
    chk("late_y", 0, 64'(fy[0]), 64'h2345_6789);
    chk("late_err", 1, 64'(ferr[1]), 64'd1);
    chk("late_y", 1, 64'(fy[1]), 64'd0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 299) == 0), 2'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 8), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
